// File: rtl/norm_shift_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : norm_shift_ctrl_pkg
// Description : Shared FSM state encodings and default widths for the
//               normalisation shift controller.
// Revision    : 1.0 - initial release
// ============================================================================
package norm_shift_ctrl_pkg;

    localparam int NORM_WIDTH = 16;
    localparam int NORM_CNT_W = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

endpackage : norm_shift_ctrl_pkg
`default_nettype wire

// File: rtl/norm_shift_cnt.sv
`default_nettype none
// ============================================================================
// Module      : norm_shift_cnt
// Description : Shift counter with synchronous clear, enable and a terminal
//               count flag at WIDTH-1; asynchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module norm_shift_cnt #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_tc
);

    localparam logic [CNT_W-1:0] c_TC = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == c_TC);

endmodule : norm_shift_cnt
`default_nettype wire

// File: rtl/norm_shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : norm_shift_ctrl
// Description : Load/shift-left sequencer producing the leading-zero count
//               and zero flag of an operand. Optional macro
//               NORM_EARLY_ZERO_EN finishes zero operands in the first
//               SHIFT cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module norm_shift_ctrl
    import norm_shift_ctrl_pkg::*;
#(
    parameter int WIDTH = NORM_WIDTH,
    parameter int CNT_W = NORM_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             ready,
    input  logic [WIDTH-1:0] sh_q,
    output logic             sh_ld,
    output logic             sh_en,
    output logic             done,
    output logic [CNT_W-1:0] shamt,
    output logic             zero
);

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [CNT_W-1:0] w_cnt;
    logic             w_tc;
    logic             w_msb;
    logic             w_in_shift;
    logic             w_accept;
    logic             w_early_zero;
    logic             w_fin_msb;
    logic             w_fin_zero;
    logic             w_unused_sh;

    assign w_msb      = sh_q[WIDTH-1];
    assign w_in_shift = (r_state == S_SHIFT);
    assign ready      = (r_state == S_IDLE);
    assign sh_ld      = (r_state == S_LOAD);
    assign done       = (r_state == S_DONE);
    assign w_accept   = ready & start;

    // The counter only reads zero in the first SHIFT cycle, since every later one follows an increment.
`ifdef NORM_EARLY_ZERO_EN
    assign w_early_zero = w_in_shift && (w_cnt == '0) && (sh_q == '0);
    assign w_unused_sh  = 1'b0;
`else
    assign w_early_zero = 1'b0;
    assign w_unused_sh  = ^sh_q[WIDTH-2:0];
`endif

    assign w_fin_msb  = w_in_shift && !w_early_zero && w_msb;
    assign w_fin_zero = w_in_shift && (w_early_zero || (!w_msb && w_tc));
    assign sh_en      = w_in_shift && !w_early_zero && !w_msb && !w_tc;

    norm_shift_cnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_accept),
        .i_en  (sh_en),
        .o_cnt (w_cnt),
        .o_tc  (w_tc)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_LOAD;
            S_LOAD:  w_next = S_SHIFT;
            S_SHIFT: if (w_fin_msb || w_fin_zero) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            shamt   <= '0;
            zero    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                shamt <= '0;
                zero  <= 1'b0;
            end else if (w_fin_msb) begin
                shamt <= w_cnt;
                zero  <= 1'b0;
            end else if (w_fin_zero) begin
                shamt <= '0;
                zero  <= 1'b1;
            end
        end
    end

endmodule : norm_shift_ctrl
`default_nettype wire

// File: tb/tb_norm_shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_norm_shift_ctrl
// Description : Directed bench pairing norm_shift_ctrl with a 16-bit
//               load/shift-left register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_norm_shift_ctrl;

    localparam int c_W = 16;
    localparam int c_CW = 4;
`ifdef NORM_EARLY_ZERO_EN
    localparam int c_ZLAT = 2;
    localparam int c_ZSH  = 0;
`else
    localparam int c_ZLAT = 17;
    localparam int c_ZSH  = 15;
`endif

    typedef struct {
        logic [15:0] op;
        int          exp_shamt;
        int          exp_zero;
        int          exp_lat;
        int          exp_nsh;
        logic [15:0] exp_final;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             ready;
    logic [c_W-1:0]   sh_q;
    logic             sh_ld;
    logic             sh_en;
    logic             done;
    logic [c_CW-1:0]  shamt;
    logic             zero;
    logic [15:0]      operand = '0;

    int checks = 0;
    int failures = 0;
    vec_t vecs[8];

    always #5 clk = ~clk;

    // Load/shift-left register under control of the DUT; its reset is ~rst.
    always @(posedge clk or posedge (~rst)) begin
        if (!rst)       sh_q <= '0;
        else if (sh_ld) sh_q <= operand;
        else if (sh_en) sh_q <= {sh_q[c_W-2:0], 1'b0};
    end

    norm_shift_ctrl #(.WIDTH(c_W), .CNT_W(c_CW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .ready (ready),
        .sh_q  (sh_q),
        .sh_ld (sh_ld),
        .sh_en (sh_en),
        .done  (done),
        .shamt (shamt),
        .zero  (zero)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one normalisation; optionally keep start asserted while busy.
    task automatic run_op(input vec_t v, input bit hold_start);
        int edges = 0;
        int nsh = 0;
        int nld = 0;
        int ndone = 0;
        int bad_ready = 0;
        int overlap = 0;
        bit got = 0;
        operand = v.op;
        start = 1'b1;
        tick();
        if (!hold_start) start = 1'b0;
        check($sformatf("cleared_%h", v.op), {27'd0, zero, shamt}, 0);
        while (!got && edges < 40) begin
            if (done) begin
                got = 1;
            end else begin
                if (sh_ld) nld++;
                if (sh_en) nsh++;
                if (ready) bad_ready++;
                if (sh_ld && sh_en) overlap++;
                tick();
                edges++;
            end
        end
        check($sformatf("done_seen_%h", v.op), int'(got), 1);
        check($sformatf("latency_%h", v.op), edges, v.exp_lat);
        check($sformatf("nshift_%h", v.op), nsh, v.exp_nsh);
        check($sformatf("nload_%h", v.op), nld, 1);
        check($sformatf("shamt_%h", v.op), int'(shamt), v.exp_shamt);
        check($sformatf("zero_%h", v.op), int'(zero), v.exp_zero);
        check($sformatf("final_q_%h", v.op), int'(sh_q), int'(v.exp_final));
        check($sformatf("busy_ready_%h", v.op), bad_ready, 0);
        check($sformatf("ld_en_overlap_%h", v.op), overlap, 0);
        start = 1'b0;
        ndone = int'(done);
        tick();
        ndone += int'(done);
        check($sformatf("done_pulse_%h", v.op), ndone, 1);
        check($sformatf("ready_after_%h", v.op), int'(ready), 1);
        check($sformatf("shamt_held_%h", v.op), int'(shamt), v.exp_shamt);
    endtask

    initial begin
        vecs[0] = '{16'h8000, 0,  0, 2,      0,     16'h8000};
        vecs[1] = '{16'h0001, 15, 0, 17,     15,    16'h8000};
        vecs[2] = '{16'h0100, 7,  0, 9,      7,     16'h8000};
        vecs[3] = '{16'h0000, 0,  1, c_ZLAT, c_ZSH, 16'h0000};
        vecs[4] = '{16'h4000, 1,  0, 3,      1,     16'h8000};
        vecs[5] = '{16'h00F0, 8,  0, 10,     8,     16'hF000};
        vecs[6] = '{16'hFFFF, 0,  0, 2,      0,     16'hFFFF};
        vecs[7] = '{16'h0003, 14, 0, 16,     14,    16'hC000};

        tick();
        tick();
        check("reset_outputs", {26'd0, sh_ld, sh_en, done, zero, shamt}, 0);
        check("reset_ready", int'(ready), 1);
        rst = 1'b1;
        tick();
        check("idle_ready", int'(ready), 1);
        check("idle_no_strobes", {29'd0, sh_ld, sh_en, done}, 0);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i], 1'b0);
        end

        // Start held high throughout a busy operation; only one result expected.
        run_op(vecs[2], 1'b1);
        tick();
        check("held_start_idle", {30'd0, ready, done}, 2);
        run_op(vecs[4], 1'b0);

        // Reset in the third shift cycle of 0x0010 aborts with no done.
        begin
            int ndone = 0;
            operand = 16'h0010;
            start = 1'b1;
            tick();
            start = 1'b0;
            tick();
            tick();
            tick();
            check("pre_abort_shifting", int'(sh_en), 1);
            rst = 1'b0;
            #1;
            check("abort_outputs", {26'd0, sh_ld, sh_en, done, zero, shamt}, 0);
            check("abort_ready", int'(ready), 1);
            for (int j = 0; j < 3; j++) begin
                tick();
                ndone += int'(done);
            end
            rst = 1'b1;
            for (int j = 0; j < 3; j++) begin
                tick();
                ndone += int'(done);
            end
            check("abort_no_done", ndone, 0);
            run_op('{16'h0010, 11, 0, 13, 11, 16'h8000}, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_norm_shift_ctrl
`default_nettype wire
